// File: rtl/uart_tx_pkg.sv
// Shared types and line-level constants for the UART transmit path.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;
    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_parity_calc.sv
// Latches the byte and parity configuration at frame accept and derives the parity bit,
// so upstream changes during a frame cannot disturb it.
module uart_tx_parity_calc
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic                  par_en_lat,
    output logic                  par_bit
);

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;

    always_comb begin
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        if (en) begin
            data_d    = p_data;
            par_en_d  = par_en;
            par_typ_d = par_typ;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= PAR_EVEN;
        end else begin
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
        end
    end

    // Odd parity inverts the even-parity reduction of the latched byte.
    assign par_bit    = (^data_q) ^ (par_typ_q == PAR_ODD);
    assign par_en_lat = par_en_q;

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART TX frame sequencer: start, 8 serializer-supplied data bits, optional parity, stop.
// TX_OUT is a single register fed by a state mux, giving one fixed cycle of line latency.
module uart_tx_frame_ctrl
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  SER_DATA,
    input  logic                  SER_DONE,
    output logic                  SER_EN,
    output logic                  TX_OUT,
    output logic                  BUSY
);

    tx_state_e state_q, state_d;
    logic      tx_q, tx_d;
    logic      accept;
    logic      par_en_lat;
    logic      par_bit;

    // Offers are only honoured between frames.
    assign accept = (state_q == IDLE) && DATA_VALID;

    uart_tx_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .clk        (CLK),
        .rst_n      (RST),
        .en         (accept),
        .p_data     (P_DATA),
        .par_en     (PAR_EN),
        .par_typ    (PAR_TYP),
        .par_en_lat (par_en_lat),
        .par_bit    (par_bit)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = START;
            START:   state_d = DATA;
            DATA: begin
                if (SER_DONE) state_d = par_en_lat ? PARITY : STOP;
            end
            PARITY:  state_d = STOP;
            STOP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_d = LINE_IDLE;
        case (state_q)
            IDLE:    tx_d = LINE_IDLE;
            START:   tx_d = START_BIT;
            DATA:    tx_d = SER_DATA;
            PARITY:  tx_d = par_bit;
            STOP:    tx_d = STOP_BIT;
            default: tx_d = LINE_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            tx_q    <= LINE_IDLE;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
        end
    end

    assign SER_EN = (state_q == DATA);
    assign BUSY   = (state_q != IDLE);
    assign TX_OUT = tx_q;

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Bench for uart_tx_frame_ctrl with a behavioural model of the companion serializer.
module tb_uart_tx_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_en;
    logic       par_typ;
    logic       ser_data;
    logic       ser_done;
    logic       ser_en;
    logic       tx_out;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_tx_frame_ctrl #(.DATA_WIDTH(8)) dut (
        .CLK        (clk),
        .RST        (rst_n),
        .P_DATA     (p_data),
        .DATA_VALID (data_valid),
        .PAR_EN     (par_en),
        .PAR_TYP    (par_typ),
        .SER_DATA   (ser_data),
        .SER_DONE   (ser_done),
        .SER_EN     (ser_en),
        .TX_OUT     (tx_out),
        .BUSY       (busy)
    );

    // Serializer model: loads on an accepted offer, shifts LSB first while enabled.
    logic [7:0] ser_sh;
    logic [2:0] ser_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ser_sh  <= '0;
            ser_cnt <= '0;
        end else if (data_valid && !busy) begin
            ser_sh  <= p_data;
            ser_cnt <= '0;
        end else if (ser_en) begin
            ser_sh  <= ser_sh >> 1;
            ser_cnt <= ser_cnt + 3'd1;
        end
    end
    assign ser_data = ser_sh[0];
    assign ser_done = ser_en && (ser_cnt == 3'd7);

    typedef struct {
        string       name;
        logic [7:0]  data;
        logic        pe;
        logic        pt;
        logic [0:10] line;   // TX_OUT after edges N+1..N+11, leftmost first
        int          len;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one frame from IDLE and check line, BUSY and SER_EN for 11 cycles.
    task automatic run_frame(input string nm, input logic [7:0] d, input logic pe,
                             input logic pt, input logic [0:10] line, input int len,
                             input bit noise);
        p_data     = d;
        par_en     = pe;
        par_typ    = pt;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        chk({nm, " busy@accept"}, busy, 1'b1);
        chk({nm, " tx@accept"}, tx_out, 1'b1);
        for (int cyc = 0; cyc < 11; cyc++) begin
            if (noise && (cyc + 1 < len)) begin
                p_data     = 8'($urandom);
                par_en     = cyc[0];
                par_typ    = ~cyc[0];
                data_valid = ~cyc[0];
            end else begin
                data_valid = 1'b0;
            end
            tick();
            chk($sformatf("%s tx[%0d]", nm, cyc), tx_out, line[cyc]);
            chk($sformatf("%s busy[%0d]", nm, cyc), busy, (cyc + 1 < len));
            chk($sformatf("%s ser_en[%0d]", nm, cyc), ser_en, (cyc <= 7));
        end
        data_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
        $fatal(1, "timeout");
    end

    initial begin
        int waited;

        vecs[0] = '{"a5_nopar",  8'hA5, 1'b0, 1'b0, 11'b0_10100101_1_1, 10};
        vecs[1] = '{"03_even",   8'h03, 1'b1, 1'b0, 11'b0_11000000_0_1, 11};
        vecs[2] = '{"03_odd",    8'h03, 1'b1, 1'b1, 11'b0_11000000_1_1, 11};
        vecs[3] = '{"00_odd",    8'h00, 1'b1, 1'b1, 11'b0_00000000_1_1, 11};
        vecs[4] = '{"ff_even",   8'hFF, 1'b1, 1'b0, 11'b0_11111111_0_1, 11};
        vecs[5] = '{"55_nopar",  8'h55, 1'b0, 1'b1, 11'b0_10101010_1_1, 10};
        vecs[6] = '{"80_even",   8'h80, 1'b1, 1'b0, 11'b0_00000001_1_1, 11};

        rst_n      = 1'b0;
        p_data     = 8'h00;
        data_valid = 1'b0;
        par_en     = 1'b0;
        par_typ    = 1'b0;
        #12;
        chk("reset tx", tx_out, 1'b1);
        chk("reset busy", busy, 1'b0);
        chk("reset ser_en", ser_en, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();

        foreach (vecs[i])
            run_frame(vecs[i].name, vecs[i].data, vecs[i].pe, vecs[i].pt,
                      vecs[i].line, vecs[i].len, 1'b0);

        // Back-to-back: 0x55 then 0xFF, second offer in the cycle BUSY falls.
        p_data     = 8'h55;
        par_en     = 1'b0;
        par_typ    = 1'b0;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        waited = 0;
        while (busy && waited < 20) begin
            tick();
            waited++;
        end
        chk("b2b busy_fall_cycle", (waited == 10), 1'b1);
        chk("b2b stop_bit", tx_out, 1'b1);
        p_data     = 8'hFF;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        chk("b2b idle_gap", tx_out, 1'b1);
        chk("b2b busy2", busy, 1'b1);
        tick();
        chk("b2b start2", tx_out, 1'b0);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("b2b ff_bit[%0d]", k), tx_out, 1'b1);
        end
        tick();
        chk("b2b stop2", tx_out, 1'b1);
        chk("b2b busy2_end", busy, 1'b0);
        tick();
        chk("b2b idle_after", tx_out, 1'b1);

        // Reset during DATA bit 4 of 0xA5; line currently shows bit 3 (0).
        p_data     = 8'hA5;
        par_en     = 1'b1;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        repeat (5) tick();
        chk("rst pre tx_bit3", tx_out, 1'b0);
        chk("rst pre ser_en", ser_en, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst async tx", tx_out, 1'b1);
        chk("rst async busy", busy, 1'b0);
        chk("rst async ser_en", ser_en, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("rst post tx[%0d]", k), tx_out, 1'b1);
            chk($sformatf("rst post busy[%0d]", k), busy, 1'b0);
        end
        run_frame("after_rst", 8'hA5, 1'b0, 1'b0, 11'b0_10100101_1_1, 10, 1'b0);

        // Inputs churn and offers pulse mid-frame; frame must be unaffected.
        run_frame("noise_odd", 8'h03, 1'b1, 1'b1, 11'b0_11000000_1_1, 11, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("noise no_extra_busy[%0d]", k), busy, 1'b0);
            chk($sformatf("noise no_extra_tx[%0d]", k), tx_out, 1'b1);
        end
        run_frame("noise_nopar", 8'hC3, 1'b0, 1'b0, 11'b0_11000011_1_1, 10, 1'b1);
        tick();
        chk("noise2 no_extra_busy", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
